// File: rtl/fpu_operand_loader_pkg.sv
// Shared constants and types for the fp32 -> 1/6/25 operand loader.
// Field widths, rebias constants, flag indices and loader FSM states.
package fpu_pkg;

   localparam int EXP_W  = 6;
   localparam int MANT_W = 25;

   localparam int FPU_BIAS  = 31;
   localparam int FP32_BIAS = 127;

   localparam logic [7:0] REBIAS  = 8'd96;
   localparam logic [7:0] E_MIN32 = 8'd96;
   localparam logic [7:0] E_MAX32 = 8'd159;

   localparam int FLAG_INVALID   = 0;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 2;
   localparam int FLAG_ZERO      = 3;

   typedef enum logic [1:0] {
      IDLE,
      CONV_A,
      CONV_B,
      HOLD
   } loader_state_t;

endpackage

// File: rtl/fpu_operand_loader_if.sv
// Operand-pair handshake bundle between producer and loader.
// master drives the pair, slave (the loader) returns ready.
interface fpu_operand_loader_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a_fp32;
   logic [31:0] in_b_fp32;

   modport master (
      output in_valid,
      output in_a_fp32,
      output in_b_fp32,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_a_fp32,
      input  in_b_fp32,
      output in_ready
   );

endinterface

// File: rtl/fpu_operand_loader_conv.sv
// Combinational binary32 -> 1/6/25 converter, one operand.
// Range checks derive from the 8-bit rebiased exponent.
module fp32_to_fpu_conv
   import fpu_pkg::*;
(
   input  logic [31:0] fp32,
   output logic [31:0] value,
   output logic [3:0]  flags
);

   logic        s;
   logic [7:0]  e;
   logic [22:0] m;
   logic [7:0]  diff;
   logic        is_nan;
   logic        is_zero;
   logic        is_unf;
   logic        is_ovf;

   assign s    = fp32[31];
   assign e    = fp32[30:23];
   assign m    = fp32[22:0];
   assign diff = e - REBIAS;

   assign is_nan  = (e == 8'hFF);
   assign is_zero = (e == 8'h00) && (m == 23'h0);
   assign is_unf  = (e < E_MIN32) && !is_zero;
   // In-range exponents leave diff below 64; anything above spills into [7:6]
   assign is_ovf  = !is_nan && (e >= E_MIN32) && (diff[7:6] != 2'b00);

   always_comb begin
      value = {s, diff[EXP_W-1:0], m, 2'b00};
      flags = '0;
      unique case (1'b1)
         is_nan: begin
            value = {s, 6'h3F, {MANT_W{1'b1}}};
            flags[FLAG_INVALID] = 1'b1;
         end
         is_zero: begin
            value = {s, 31'b0};
            flags[FLAG_ZERO] = 1'b1;
         end
         is_unf: begin
            value = {s, 31'b0};
            flags[FLAG_UNDERFLOW] = 1'b1;
         end
         is_ovf: begin
            value = {s, 6'h3F, {MANT_W{1'b1}}};
            flags[FLAG_OVERFLOW] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fpu_operand_loader.sv
// Operand loader: accepts an fp32 pair, converts A then B, holds ops_valid.
// Optional FPU result capture enabled by FPU_LOADER_RESULT_CAPTURE_EN.
module fpu_operand_loader
   import fpu_pkg::*;
#(
   parameter int HOLD_CYCLES = 40,
   parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   fpu_operand_loader_if.slave  in_bus,
   output logic [31:0]          op_A_out,
   output logic [31:0]          op_B_out,
   output logic                 ops_valid,
   output logic [3:0]           conv_flags,
`ifdef FPU_LOADER_RESULT_CAPTURE_EN
   input  logic [31:0]          fpu_data_in,
   input  logic [3:0]           fpu_status_in,
   output logic [31:0]          result_out,
   output logic [3:0]           result_status,
   output logic                 result_valid,
`endif
   output logic                 busy
);

   loader_state_t state;
   logic [31:0]   raw_a;
   logic [31:0]   raw_b;
   logic [CNT_W-1:0] cnt;
   logic [31:0]   conv_in;
   logic [31:0]   conv_val;
   logic [3:0]    conv_flg;
   logic          last_hold;

   assign in_bus.in_ready = (state == IDLE);
   assign busy            = (state != IDLE);
   assign ops_valid       = (state == HOLD);
   assign last_hold       = (state == HOLD) && (cnt == CNT_W'(1));

   // One converter shared across the two conversion cycles
   assign conv_in = (state == CONV_B) ? raw_b : raw_a;

   fp32_to_fpu_conv u_conv (
      .fp32  (conv_in),
      .value (conv_val),
      .flags (conv_flg)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         raw_a      <= '0;
         raw_b      <= '0;
         op_A_out   <= '0;
         op_B_out   <= '0;
         conv_flags <= '0;
         cnt        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_bus.in_valid) begin
                  raw_a      <= in_bus.in_a_fp32;
                  raw_b      <= in_bus.in_b_fp32;
                  conv_flags <= '0;
                  state      <= CONV_A;
               end
            end
            CONV_A: begin
               op_A_out   <= conv_val;
               conv_flags <= conv_flags | conv_flg;
               state      <= CONV_B;
            end
            CONV_B: begin
               op_B_out   <= conv_val;
               conv_flags <= conv_flags | conv_flg;
               cnt        <= CNT_W'(HOLD_CYCLES);
               state      <= HOLD;
            end
            HOLD: begin
               cnt <= cnt - CNT_W'(1);
               if (last_hold) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FPU_LOADER_RESULT_CAPTURE_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         result_out    <= '0;
         result_status <= '0;
         result_valid  <= 1'b0;
      end else begin
         result_valid <= last_hold;
         if (last_hold) begin
            result_out    <= fpu_data_in;
            result_status <= fpu_status_in;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed self-checking bench for fpu_operand_loader.
// Covers reset, conversion vectors, back-to-back pressure, mid-HOLD reset.
module tb_fpu_operand_loader;

   localparam int HOLD = 40;

   logic        clock;
   logic        reset;
   logic [31:0] op_A_out;
   logic [31:0] op_B_out;
   logic        ops_valid;
   logic [3:0]  conv_flags;
   logic        busy;
`ifdef FPU_LOADER_RESULT_CAPTURE_EN
   logic [31:0] fpu_data_in;
   logic [3:0]  fpu_status_in;
   logic [31:0] result_out;
   logic [3:0]  result_status;
   logic        result_valid;
`endif

   int checks;
   int errors;

   fpu_operand_loader_if bus ();

   fpu_operand_loader #(.HOLD_CYCLES(HOLD)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_bus        (bus.slave),
      .op_A_out      (op_A_out),
      .op_B_out      (op_B_out),
      .ops_valid     (ops_valid),
      .conv_flags    (conv_flags),
`ifdef FPU_LOADER_RESULT_CAPTURE_EN
      .fpu_data_in   (fpu_data_in),
      .fpu_status_in (fpu_status_in),
      .result_out    (result_out),
      .result_status (result_status),
      .result_valid  (result_valid),
`endif
      .busy          (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic test_reset;
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a_fp32 = '0;
      bus.in_b_fp32 = '0;
`ifdef FPU_LOADER_RESULT_CAPTURE_EN
      fpu_data_in = '0;
      fpu_status_in = '0;
`endif
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({op_A_out, op_B_out, ops_valid, conv_flags, busy} !== 70'd0) begin
         errors++;
         $display("FAIL reset_outs: A=%h B=%h v=%b f=%b busy=%b want all 0",
                  op_A_out, op_B_out, ops_valid, conv_flags, busy);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input logic [3:0] ef, input string nm);
      int t;
      int lat;
      int hi;
      t = 0;
      @(negedge clock);
      while (!bus.in_ready && t < 200) begin
         @(negedge clock);
         t++;
      end
      checks++;
      if (!bus.in_ready) begin
         errors++;
         $display("FAIL %s_ready_timeout: in_ready=%b want 1", nm, bus.in_ready);
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_a_fp32 = a;
      bus.in_b_fp32 = b;
`ifdef FPU_LOADER_RESULT_CAPTURE_EN
      fpu_data_in = a ^ b;
      fpu_status_in = ef;
`endif
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!ops_valid && lat < 10) begin
         @(posedge clock);
         #1;
         lat++;
      end
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles want 3", nm, lat);
      end
      hi = 0;
      while (ops_valid && hi < 200) begin
         hi++;
         @(posedge clock);
         #1;
      end
      checks++;
      if (hi !== HOLD) begin
         errors++;
         $display("FAIL %s_hold_len: got %0d want %0d", nm, hi, HOLD);
      end
      checks++;
      if (op_A_out !== ea) begin
         errors++;
         $display("FAIL %s_opA: got %h want %h", nm, op_A_out, ea);
      end
      checks++;
      if (op_B_out !== eb) begin
         errors++;
         $display("FAIL %s_opB: got %h want %h", nm, op_B_out, eb);
      end
      checks++;
      if (conv_flags !== ef) begin
         errors++;
         $display("FAIL %s_flags: got %b want %b", nm, conv_flags, ef);
      end
      checks++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: ready=%b busy=%b want 1/0",
                  nm, bus.in_ready, busy);
      end
`ifdef FPU_LOADER_RESULT_CAPTURE_EN
      checks++;
      if (result_valid !== 1'b1 || result_out !== (a ^ b)
          || result_status !== ef) begin
         errors++;
         $display("FAIL %s_result: v=%b d=%h s=%b want 1 %h %b",
                  nm, result_valid, result_out, result_status, a ^ b, ef);
      end
`endif
   endtask

   task automatic test_conversion;
      run_pair(32'h3F800000, 32'h40200000,
               32'h3E000000, 32'h40800000, 4'b0000, "one_2p5");
      run_pair(32'hBF800000, 32'h00000000,
               32'hBE000000, 32'h00000000, 4'b1000, "neg_zero");
      run_pair(32'h60AD78EC, 32'h1E3CE508,
               32'h7FFFFFFF, 32'h00000000, 4'b0110, "ovf_unf");
      run_pair(32'h7FC00000, 32'hFF800000,
               32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0001, "nan_inf");
   endtask

   task automatic test_back_to_back;
      int last;
      int nacc;
      int gap;
      int t;
      logic prev_rdy;
      logic was_valid;
      logic [31:0] ha;
      logic [31:0] hb;
      logic [3:0]  hf;
      last = -1;
      nacc = 0;
      was_valid = 1'b0;
      ha = '0;
      hb = '0;
      hf = '0;
      @(negedge clock);
      prev_rdy = bus.in_ready;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3 * (HOLD + 4) + 4; i++) begin
         bus.in_a_fp32 = 32'h3F800000 ^ (32'(i) << 4);
         bus.in_b_fp32 = 32'hC0200000 ^ (32'(i) << 6);
         @(posedge clock);
         #1;
         if (prev_rdy) begin
            if (last >= 0) begin
               gap = i - last;
               checks++;
               if (gap < HOLD + 3 || gap > HOLD + 4) begin
                  errors++;
                  $display("FAIL b2b_period: got %0d want %0d..%0d",
                           gap, HOLD + 3, HOLD + 4);
               end
            end
            last = i;
            nacc++;
         end
         if (busy !== !bus.in_ready || (bus.in_ready && ops_valid)) begin
            checks++;
            errors++;
            $display("FAIL b2b_ready: ready=%b busy=%b valid=%b",
                     bus.in_ready, busy, ops_valid);
         end
         if (ops_valid && was_valid) begin
            checks++;
            if (op_A_out !== ha || op_B_out !== hb || conv_flags !== hf) begin
               errors++;
               $display("FAIL b2b_stable: A=%h B=%h f=%b want %h %h %b",
                        op_A_out, op_B_out, conv_flags, ha, hb, hf);
            end
         end
         ha = op_A_out;
         hb = op_B_out;
         hf = conv_flags;
         was_valid = ops_valid;
         prev_rdy = bus.in_ready;
         @(negedge clock);
      end
      bus.in_valid = 1'b0;
      checks++;
      if (nacc !== 4) begin
         errors++;
         $display("FAIL b2b_accepts: got %0d want 4", nacc);
      end
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(negedge clock);
         t++;
      end
   endtask

   task automatic test_reset_mid_hold;
      int t;
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_a_fp32 = 32'h3F800000;
      bus.in_b_fp32 = 32'h40200000;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      t = 0;
      while (!ops_valid && t < 10) begin
         @(posedge clock);
         #1;
         t++;
      end
      repeat (9) @(posedge clock);
      #3;
      checks++;
      if (ops_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: ops_valid=%b want 1", ops_valid);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({op_A_out, op_B_out, ops_valid, conv_flags, busy} !== 70'd0
          || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: A=%h B=%h v=%b f=%b busy=%b rdy=%b want 0",
                  op_A_out, op_B_out, ops_valid, conv_flags, busy, bus.in_ready);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || ops_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_release: ready=%b valid=%b want 1/0",
                  bus.in_ready, ops_valid);
      end
      run_pair(32'h40200000, 32'hBF800000,
               32'h40800000, 32'hBE000000, 4'b0000, "post_reset");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_conversion();
      test_back_to_back();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
